// File: rtl/snake_ctrl_if.sv
// Control inputs and position outputs of the snake sequencer.
// The master drives the controls; the slave (snake_ctrl) drives position and status.
interface snake_ctrl_if;
  logic       start;
  logic       stop;
  logic       hold;
  logic       step;
  logic       dir;
  logic [1:0] speed;
  logic [4:0] addr;
  logic       adv;
  logic       lap;
  logic       busy;
  logic [1:0] state;

  modport master (
    output start, stop, hold, step, dir, speed,
    input  addr, adv, lap, busy, state
  );

  modport slave (
    input  start, stop, hold, step, dir, speed,
    output addr, adv, lap, busy, state
  );
endinterface

// File: rtl/snake_ctrl.sv
// Snake position sequencer: walks addr around a LEN-long path at a prescaled rate.
// It can also pause, single-step, reverse direction and change speed on the fly.
module snake_ctrl #(
  parameter int unsigned LEN = 20,
  parameter int unsigned DIV = 2500000
) (
  input  logic        clk,
  input  logic        rst,
  snake_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  localparam logic [4:0] LAST = 5'(LEN - 1);

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [4:0]  addr_q;
  logic        adv_q;
  logic        lap_q;

  logic [31:0] limit;
  logic        tick;
  logic [4:0]  addr_d;
  logic        lap_d;

  // Candidate next position is always ready; the FSM decides whether to take it.
  always_comb begin
    limit  = (32'(DIV) << bus.speed) - 32'd1;
    tick   = (cnt_q >= limit);
    addr_d = addr_q;
    lap_d  = 1'b0;
    if (bus.dir) begin
      if (addr_q == '0) begin
        addr_d = LAST;
        lap_d  = 1'b1;
      end else begin
        addr_d = addr_q - 5'd1;
      end
    end else begin
      if (addr_q == LAST) begin
        addr_d = '0;
        lap_d  = 1'b1;
      end else begin
        addr_d = addr_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.stop) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      adv_q   <= 1'b0;
      lap_q   <= 1'b0;
    end else begin
      adv_q <= 1'b0;
      lap_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          addr_q <= '0;
          if (bus.start) state_q <= RUN;
        end
        RUN: begin
          if (tick) begin
            cnt_q  <= '0;
            addr_q <= addr_d;
            adv_q  <= 1'b1;
            lap_q  <= lap_d;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
          // A tick coinciding with hold still lands before pausing.
          if (bus.hold) state_q <= PAUSE;
        end
        PAUSE: begin
          if (bus.step) begin
            addr_q <= addr_d;
            adv_q  <= 1'b1;
            lap_q  <= lap_d;
          end
          if (!bus.hold) state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.addr  = addr_q;
  assign bus.adv   = adv_q;
  assign bus.lap   = lap_q;
  assign bus.state = state_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: doc/snake_ctrl.md
SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 SHALL have parameter LEN, default 20: number of snake positions in the path (legal range 2..32).
REQ-002 SHALL have parameter DIV, default 2500000: base clock cycles per advance at speed 0 (legal range 1..2^28).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: begin running from IDLE.
REQ-006 SHALL have port stop, input, 1 bit: return to IDLE from any state.
REQ-007 SHALL have port hold, input, 1 bit, level: pause while high.
REQ-008 SHALL have port step, input, 1 bit: single-advance request, honoured in PAUSE only.
REQ-009 SHALL have port dir, input, 1 bit: 0 = forward (increment), 1 = reverse (decrement).
REQ-010 SHALL have port speed, input, 2 bits: advance period = DIV << speed cycles.
REQ-011 SHALL have port addr, output, 5 bits: current snake position, driving the segment-pattern ROM address inputs.
REQ-012 SHALL have port adv, output, 1 bit: one-cycle pulse in the cycle addr takes a new value.
REQ-013 SHALL have port lap, output, 1 bit: one-cycle pulse coincident with adv when addr wraps.
REQ-014 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-015 SHALL have port state, output, 2 bits: IDLE = 00, RUN = 01, PAUSE = 10; 11 is unused.

Function
REQ-016 SHALL implement a 32-bit prescaler cnt with limit = (DIV << speed) - 1.
REQ-017 In RUN, when cnt >= limit, SHALL raise an internal tick and clear cnt; otherwise SHALL increment cnt. The >= compare covers a speed reduction mid-count, which then ticks on the next cycle.
REQ-018 On a tick or an honoured step, SHALL advance addr and pulse adv in the same registered update.
REQ-019 With dir=0, SHALL advance addr from addr to addr+1, and from LEN-1 to 0 with lap=1.
REQ-020 With dir=1, SHALL advance addr from addr to addr-1, and from 0 to LEN-1 with lap=1.
REQ-021 SHALL sample dir and speed every cycle; a change affects only the next advance and never alters addr directly.
REQ-022 SHALL make the IDLE -> RUN transition when start=1 and stop=0; cnt starts from 0, and the first advance comes DIV<<speed cycles after entry.
REQ-023 SHALL make the RUN -> PAUSE transition when hold=1; cnt is frozen (retained) in PAUSE.
REQ-024 SHALL make the PAUSE -> RUN transition when hold=0; counting resumes from the retained cnt.
REQ-025 In PAUSE, each cycle with step=1 SHALL advance addr by exactly one position; step is ignored in IDLE and RUN.
REQ-026 SHALL make the transition from any state to IDLE when stop=1; stop has priority over start, hold, step and tick.
REQ-027 On entering IDLE, addr, cnt, adv and lap SHALL be 0 on the next cycle.
REQ-028 In IDLE, addr SHALL hold 0, cnt SHALL hold 0, and adv and lap SHALL stay 0.
REQ-029 When a tick and hold=1 coincide in RUN, the tick SHALL take effect (addr advances) and the state SHALL still go to PAUSE.
REQ-030 adv and lap SHALL be registered, with a maximum width of 1 cycle, and SHALL never be high in IDLE.
REQ-031 addr SHALL always be < LEN.

Reset
REQ-032 When rst=1 at a clock edge, the next state SHALL be: state=IDLE, addr=0, cnt=0, adv=0, lap=0, busy=0.
REQ-033 rst SHALL override all other inputs, including mid-RUN or mid-PAUSE.
REQ-034 Operation SHALL resume only through start after rst deasserts.

Verification (DIV=4, LEN=20)
REQ-035 SHALL verify: reset, then start pulse with speed=0, dir=0 -> adv every 4 cycles; addr 0,1,2,...,19,0; lap pulses at the 19->0 step only.
REQ-036 SHALL verify: dir=1 from addr=0 in RUN -> the next advance gives addr=19 with lap=1, then 18.
REQ-037 SHALL verify: speed=2 -> adv every 16 cycles; switching to speed=0 when cnt=10 -> tick on the next cycle, then every 4 cycles.
REQ-038 SHALL verify: hold=1 at addr=5 with cnt=2 -> state=PAUSE, addr frozen; three step pulses -> addr=8 with 3 adv pulses; hold=0 -> first advance after 2 more cycles.
REQ-039 SHALL verify: start and stop high together in IDLE -> stays IDLE; stop in RUN at addr=12 -> next cycle addr=0, busy=0, state=00.
REQ-040 SHALL verify: rst asserted in PAUSE at addr=7 -> next cycle all outputs 0; start is then required to run again.
